cdm_seq_mult: RTL and testbench

//   Parametrised sequential carry-disregard multiplier: the AW x BW successor of the fixed 8x4 combinational array.

---
 rtl/cdm_seq_mult.sv | 126 ++++++++++++
 tb/tb_cdm_seq_mult.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cdm_seq_mult.sv
// cdm_seq_mult: sequential AW x BW shift-add multiplier with an optional
// carry-disregard mode. One multiplier row is accumulated per clock. In
// approximate mode the low K result columns are combined by XOR, so no carry
// is generated in them and none crosses into column K; the upper columns
// accumulate exactly. Valid/ready handshake on both operand and result sides.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   block can accept operands (high only in IDLE)
//   in_a       multiplicand, AW bits, unsigned
//   in_b       multiplier, BW bits, unsigned
//   in_approx  1 = carry-disregard in the low K columns, 0 = exact
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   out_r      registered product, AW+BW bits
//   out_approx mode the presented result was computed in
module cdm_seq_mult #(
  parameter int unsigned AW = 8,
  parameter int unsigned BW = 4,
  parameter int unsigned K  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_a,
  input  logic [BW-1:0]    in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW+BW-1:0] out_r,
  output logic             out_approx
);

  localparam int unsigned W  = AW + BW;
  localparam int unsigned RW = $clog2(BW);

  // Columns below K are carry-free in approximate mode. K=0 leaves the mask
  // empty, which makes both modes identical (always exact).
  localparam logic [W-1:0] LOW_MASK = (K == 0) ? '0 : ((W'(1) << K) - W'(1));

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q;
  logic [BW-1:0]   b_q;
  logic            approx_q;
  logic [RW-1:0]   row_q;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    pp;
  logic            accept;
  logic            last_row;

  assign accept   = in_valid && in_ready;
  assign last_row = (row_q == RW'(BW - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_row) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Row accumulation. The upper columns are added with the low columns
  // masked to zero in both operands, so that sum can never receive a carry
  // out of column K-1; the low columns are XORed separately.
  always_comb begin
    pp = ({{BW{1'b0}}, a_q} & {W{b_q[row_q]}}) << row_q;
    if (approx_q) begin
      acc_d = ((acc_q & ~LOW_MASK) + (pp & ~LOW_MASK)) | ((acc_q ^ pp) & LOW_MASK);
    end else begin
      acc_d = acc_q + pp;
    end
  end

  // Operand latch, row counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      row_q    <= '0;
      acc_q    <= '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        a_q      <= in_a;
        b_q      <= in_b;
        approx_q <= in_approx;
        row_q    <= '0;
        acc_q    <= '0;
      end
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      row_q <= row_q + RW'(1);
    end
  end

  assign out_r      = acc_q;
  assign out_approx = approx_q;

endmodule

// File: tb/tb_cdm_seq_mult.sv
module tb_cdm_seq_mult;

  localparam int unsigned AW = 8;
  localparam int unsigned BW = 4;
  localparam int unsigned K  = 4;
  localparam int unsigned W  = AW + BW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          in_approx;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_r;
  logic          out_approx;

  int checks;
  int errors;

  cdm_seq_mult #(.AW(AW), .BW(BW), .K(K)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_approx  (in_approx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_approx (out_approx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          approx;
    logic [W-1:0]  exp_r;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact = a*b; approximate = column parity in the low K columns,
  // plus the sum of the partial products restricted to columns >= K.
  function automatic logic [W-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                          input logic ap);
    int unsigned hi;
    logic [W-1:0] lo;
    if (!ap || K == 0) return W'(int'(a) * int'(b));
    hi = 0;
    lo = '0;
    for (int r = 0; r < BW; r++)
      if (b[r]) hi += ((int'(a) << r) >> K) << K;
    for (int c = 0; c < K; c++) begin
      logic p;
      p = 1'b0;
      for (int r = 0; r < BW; r++)
        if (c - r >= 0 && c - r < AW) p ^= a[c-r] & b[r];
      lo[c] = p;
    end
    return W'(hi) | lo;
  endfunction

  // One transaction: wait for in_ready, present operands for one accept edge,
  // measure cycles to out_valid, optionally hold out_ready low, then complete.
  task automatic do_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic ap,
                       input logic [W-1:0] exp_r, input int hold, input logic early,
                       input string tag);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_a      = a;
    in_b      = b;
    in_approx = ap;
    in_valid  = 1'b1;
    out_ready = early;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    // accept cycle counts as 1; BW CALC cycles follow; result in cycle BW+1
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(BW + 1));
    check({tag, " out_r"}, 32'(out_r), 32'(exp_r));
    check({tag, " out_approx"}, 32'(out_approx), 32'(ap));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " held out_r"}, 32'(out_r), 32'(exp_r));
        check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_approx = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{8'hFF, 4'hF, 1'b0, 12'hEF1};
    vecs[1] = '{8'hFF, 4'hF, 1'b1, 12'hEC5};
    vecs[2] = '{8'h03, 4'h3, 1'b1, 12'h005};
    vecs[3] = '{8'h03, 4'h3, 1'b0, 12'h009};
    vecs[4] = '{8'h00, 4'hF, 1'b1, 12'h000};
    vecs[5] = '{8'hAB, 4'h0, 1'b0, 12'h000};
    vecs[6] = '{8'h01, 4'h1, 1'b1, 12'h001};
    vecs[7] = '{8'h80, 4'h8, 1'b1, 12'h400};
    vecs[8] = '{8'h0F, 4'hF, 1'b1, 12'h0B5};
    vecs[9] = '{8'h0F, 4'hF, 1'b0, 12'h0E1};

    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_r", 32'(out_r), 32'd0);
    check("reset out_approx", 32'(out_approx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].approx, vecs[i].exp_r, 0, 1'b0,
            $sformatf("vec%0d", i));

    // Backpressure: result held for 10 cycles with out_ready low
    do_op(8'hFF, 4'hF, 1'b1, 12'hEC5, 10, 1'b0, "backpressure");

    // out_ready already high while computing: completes on the first DONE cycle
    do_op(8'h03, 4'h3, 1'b1, 12'h005, 0, 1'b1, "early_ready");

    // Reset during the second CALC cycle aborts the operation
    in_a      = 8'hFF;
    in_b      = 4'hF;
    in_approx = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop reset out_valid", 32'(out_valid), 32'd0);
    check("midop reset in_ready", 32'(in_ready), 32'd1);
    check("midop reset out_r", 32'(out_r), 32'd0);
    check("midop reset out_approx", 32'(out_approx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'hFF, 4'hF, 1'b0, 12'hEF1, 0, 1'b0, "after_reset");

    // Random operands, modes and result backpressure against the model
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] ra;
      logic [BW-1:0] rb;
      logic          rap;
      ra  = AW'($urandom);
      rb  = BW'($urandom);
      rap = 1'($urandom_range(0, 1));
      do_op(ra, rb, rap, model(ra, rb, rap), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
